uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. Consumes each byte flagged by the receiver's rdy/rx_data pair and returns a clear-ready pulse. Stores bytes in a first-word-fall-through FIFO for the core and raises overrun, threshold and (optionally) idle-timeout interrupts.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2.
CW, $clog2(DEPTH)+1, width of count/threshold (derived; do not override).
TO_BITS, 40, idle-timeout length in bit periods (4 characters of 10 bits).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rx_rdy  in  1  receiver byte-ready level; held high until cleared
rx_data  in  8  received byte; valid while rx_rdy=1
rx_clr_rdy  out  1  registered one-cycle pulse clearing the receiver's rdy
baudrate  in  13  clocks per bit; same value the receiver uses
rd_en  in  1  pop head entry (core read strobe)
rd_data  out  8  head entry, first-word-fall-through
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  CW  occupancy, 0..DEPTH
thresh  in  CW  irq threshold; 0 disables the threshold term
ovr_clr  in  1  clear sticky overrun
overrun  out  1  sticky: byte dropped because FIFO full
rx_timeout  out  1  sticky idle-timeout flag
irq  out  1  interrupt request

Behaviour:
- Reset values: rx_clr_rdy=0, empty=1, full=0, count=0, overrun=0, rx_timeout=0, irq=0, rd_data=8'h00. Read/write pointers are 0. Storage array is not reset.
- Capture occurs when rx_rdy=1 and rx_clr_rdy=0 at a clock edge:
  - rx_clr_rdy goes to 1 for exactly one cycle.
  - rx_rdy is ignored while rx_clr_rdy=1, because rdy drops one cycle later. Each byte is pushed exactly once.
- Push: on capture, if the FIFO is not full (or is full with rd_en=1 that same edge), write rx_data at wr_ptr and advance wr_ptr. The byte appears at rd_data and empty deasserts on the cycle after the capture edge.
- Push while full and rd_en=0: byte dropped, overrun set to 1, rx_clr_rdy still pulses. Pointers and count are unchanged.
- Pop: rd_en=1 with empty=0 advances rd_ptr. rd_en while empty is ignored, with no underflow or pointer change.
- Push and pop on the same edge: both take effect and count is unchanged. When empty, only the push takes effect.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count: registered; +1 on push-only, -1 on pop-only.
- Flags: empty = (count==0), full = (count==DEPTH).
- rd_data = mem[rd_ptr] when !empty, 8'h00 when empty.
- overrun: set on drop, cleared by ovr_clr. Set wins if both occur on the same edge.
- irq is registered, one cycle after its source condition:
  - irq = overrun | rx_timeout | ((thresh!=0) && (count>=thresh)).
- Mid-operation reset: all state returns to the reset values immediately. A pending rx_rdy is re-captured after reset release.

Optional Feature:
Macro RX_TIMEOUT_EN.
- Defined:
  - 13-bit baud counter loads baudrate and decrements each clk while !empty.
  - On reaching 0, it reloads and increments a 6-bit bit-period counter.
  - Both counters clear on any push, any pop, or when empty.
  - When the bit-period counter reaches TO_BITS, set rx_timeout. The counters then hold until cleared.
  - rx_timeout clears on a pop, or when the FIFO becomes empty.
- Undefined: rx_timeout is tied to 0, no counter logic is present, and the irq term is constant 0.

Test Plan:
- Single byte: rx_rdy=1, rx_data=8'hA5 held until clr -> exactly one rx_clr_rdy pulse; next cycle empty=0, count=1, rd_data=8'hA5. Then rd_en for 1 cycle -> empty=1, rd_data=8'h00.
- Fill, DEPTH=8: push 8'h01..8'h08 -> full=1, count=8. A 9th byte 8'h09 -> dropped, overrun=1, irq=1, rx_clr_rdy still pulses. Pop 8 times -> reads 01..08 in order; 09 is never seen.
- Wrap and simultaneous: with count=8, push 8'h10 with rd_en on the same edge -> count stays 8, head advances. After 7 more pops, 8'h10 is the head.
- Underflow and threshold: with empty, rd_en=1 -> no change. With thresh=3, push 3 bytes -> irq rises the cycle after count reaches 3. Pop 1 -> irq falls next cycle.
- Overrun clear race: ovr_clr=1 on the same edge as a drop -> overrun stays 1. ovr_clr alone -> overrun=0.
- Timeout (RX_TIMEOUT_EN, baudrate=13'd16, TO_BITS=40): push 1 byte, then idle -> rx_timeout=1 after 640±2 clks, irq=1. A pop clears rx_timeout. With the macro undefined, rx_timeout stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Captures each byte flagged by rx_rdy/rx_data, answers with a one-cycle
// rx_clr_rdy pulse, and queues it in a first-word-fall-through FIFO.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_rdy, rx_data       receiver byte-ready level and byte
//   rx_clr_rdy            registered pulse clearing the receiver's rdy
//   baudrate              clocks per bit (idle-timeout timebase)
//   rd_en, rd_data        pop strobe and head entry (8'h00 when empty)
//   empty, full, count    occupancy status
//   thresh                irq threshold (0 disables that term)
//   ovr_clr, overrun      sticky overrun flag and its clear
//   rx_timeout            sticky idle-timeout flag
//   irq                   registered interrupt request
// Optional: define RX_TIMEOUT_EN to build the idle-timeout counters;
// otherwise rx_timeout is tied low.
module uart_rx_fifo #(
  parameter int DEPTH   = 8,
  parameter int CW      = $clog2(DEPTH) + 1,
  parameter int TO_BITS = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  output logic          rx_clr_rdy,
  input  logic [12:0]   baudrate,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  input  logic [CW-1:0] thresh,
  input  logic          ovr_clr,
  output logic          overrun,
  output logic          rx_timeout,
  output logic          irq
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          clr_q, ovr_q, irq_q;
  logic          capture, push, pop, drop;
  // rx_rdy stays high one cycle after the clear pulse, so it is masked then
  assign capture = rx_rdy && !clr_q;
  assign empty   = count_q == '0;
  assign full    = count_q == CW'(DEPTH);
  assign pop     = rd_en && !empty;
  // a full FIFO still accepts the byte when the core frees a slot this edge
  assign push    = capture && (!full || rd_en);
  assign drop    = capture && full && !rd_en;
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign rd_data    = empty ? 8'h00 : mem[rd_ptr_q];
  assign count      = count_q;
  assign rx_clr_rdy = clr_q;
  assign overrun    = ovr_q;
  assign irq        = irq_q;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr_q] <= rx_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      clr_q    <= 1'b0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q  <= count_d;
      clr_q    <= capture;
      ovr_q    <= drop | (ovr_q & ~ovr_clr);
      irq_q    <= ovr_q | rx_timeout | ((thresh != '0) && (count_q >= thresh));
    end
`ifdef RX_TIMEOUT_EN
  logic [12:0] baud_q;
  logic [5:0]  bits_q;
  logic        to_q;
  logic        tclr;
  // any FIFO activity, or nothing buffered, restarts the idle measurement
  assign tclr       = push | pop | empty;
  assign rx_timeout = to_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      baud_q <= '0;
      bits_q <= '0;
      to_q   <= 1'b0;
    end else begin
      if (tclr) begin
        baud_q <= baudrate;
        bits_q <= '0;
      end else if (bits_q != 6'(TO_BITS)) begin
        baud_q <= (baud_q <= 13'd1) ? baudrate : baud_q - 13'd1;
        bits_q <= (baud_q <= 13'd1) ? bits_q + 6'd1 : bits_q;
      end
      if (pop || empty) to_q <= 1'b0;
      else if (!push && bits_q == 6'(TO_BITS - 1) && baud_q <= 13'd1) to_q <= 1'b1;
    end
`else
  logic unused_baud;
  assign unused_baud = ^baudrate;
  assign rx_timeout  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;
  localparam int CW = 4;
  localparam int TO_BITS = 40;
  logic clk = 0, rst_n = 0;
  logic rx_rdy = 0, rd_en = 0, ovr_clr = 0;
  logic [7:0] rx_data = 0;
  logic [12:0] baudrate = 13'd16;
  logic [CW-1:0] thresh = 0;
  logic rx_clr_rdy, empty, full, overrun, rx_timeout, irq;
  logic [7:0] rd_data;
  logic [CW-1:0] count;
  int n_chk = 0, n_fail = 0;

  uart_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .rx_clr_rdy(rx_clr_rdy), .baudrate(baudrate), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .thresh(thresh), .ovr_clr(ovr_clr), .overrun(overrun),
    .rx_timeout(rx_timeout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte queue plus sticky flags, updated per clock edge
  logic [7:0] q[$];
  bit m_clr, m_ovr, m_to, m_irq;
  bit cap, mpush, mpop, mdrop, memp, mfull;
  int idle, n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_clr = 0; m_ovr = 0; m_to = 0; m_irq = 0; idle = 0;
    end else begin
      n = q.size();
      memp = n == 0;
      mfull = n == DEPTH;
      cap = rx_rdy && !m_clr;
      mpop = rd_en && !memp;
      mpush = cap && (!mfull || rd_en);
      mdrop = cap && mfull && !rd_en;
      m_irq = m_ovr | m_to | (thresh != 0 && n >= int'(thresh));
`ifdef RX_TIMEOUT_EN
      if (mpush || mpop || memp) idle = 0;
      else if (idle < 100000) idle++;
      if (mpop || memp) m_to = 0;
      else if (idle == int'(baudrate) * TO_BITS) m_to = 1;
`endif
      if (mdrop) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
      m_clr = cap;
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(rx_data);
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("full", full, q.size() == DEPTH);
      chk("rd_data", rd_data, q.size() ? q[0] : 8'h00);
      chk("clr_rdy", rx_clr_rdy, m_clr);
      chk("overrun", overrun, m_ovr);
      chk("rx_timeout", rx_timeout, m_to);
      chk("irq", irq, m_irq);
    end
  end

  task automatic send(input logic [7:0] b);
    int k = 0;
    rx_rdy = 1; rx_data = b;
    do begin @(negedge clk); k++; end while (!rx_clr_rdy && k < 20);
    if (!rx_clr_rdy) chk("send_bound", rx_clr_rdy, 1);
    rx_rdy = 0;
  endtask

  task automatic pop1();
    rd_en = 1; @(negedge clk); rd_en = 0;
  endtask

  task automatic drain();
    int k = 0;
    while (!empty && k < 40) begin pop1(); k++; end
    chk("drain_empty", empty, 1);
  endtask

  initial begin
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_clr", rx_clr_rdy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    // single byte
    send(8'hA5);
    chk("sb_clr_pulse", rx_clr_rdy, 1);
    chk("sb_count", count, 1);
    chk("sb_data", rd_data, 8'hA5);
    @(negedge clk);
    chk("sb_clr_once", rx_clr_rdy, 0);
    chk("sb_count_hold", count, 1);
    pop1();
    chk("sb_empty", empty, 1);
    chk("sb_rd_zero", rd_data, 8'h00);
    // underflow
    pop1();
    chk("uf_count", count, 0);
    chk("uf_empty", empty, 1);
    // threshold
    thresh = 3;
    send(8'h31); send(8'h32); send(8'h33);
    chk("th_count", count, 3);
    chk("th_irq_late", irq, 0);
    @(negedge clk);
    chk("th_irq", irq, 1);
    pop1();
    chk("th_irq_hold", irq, 1);
    @(negedge clk);
    chk("th_irq_fall", irq, 0);
    drain();
    thresh = 0;
    // fill and overrun
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    send(8'h09);
    chk("ovr_set", overrun, 1);
    chk("ovr_count", count, 8);
    @(negedge clk);
    chk("ovr_irq", irq, 1);
    // clear race: set wins
    rx_rdy = 1; rx_data = 8'h0A; ovr_clr = 1;
    @(negedge clk);
    ovr_clr = 0; rx_rdy = 0;
    chk("race_clr_pulse", rx_clr_rdy, 1);
    chk("race_ovr", overrun, 1);
    ovr_clr = 1; @(negedge clk); ovr_clr = 0;
    chk("ovr_cleared", overrun, 0);
    // simultaneous push/pop while full
    rx_rdy = 1; rx_data = 8'h10; rd_en = 1;
    @(negedge clk);
    rd_en = 0; rx_rdy = 0;
    chk("sim_count", count, 8);
    chk("sim_head", rd_data, 8'h02);
    for (int i = 2; i <= 8; i++) begin
      chk("order", rd_data, 8'(i));
      pop1();
    end
    chk("wrap_head", rd_data, 8'h10);
    chk("wrap_count", count, 1);
    pop1();
    chk("wrap_empty", empty, 1);
    // mid-operation reset with pending byte
    send(8'h11); send(8'h22);
    rx_rdy = 1; rx_data = 8'h55;
    #2 rst_n = 0;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_clr", rx_clr_rdy, 0);
    chk("mrst_rd", rd_data, 8'h00);
    @(negedge clk);
    rst_n = 1;
    begin
      int k = 0;
      while (!rx_clr_rdy && k < 10) begin @(negedge clk); k++; end
    end
    rx_rdy = 0;
    chk("mrst_recap", rd_data, 8'h55);
    chk("mrst_recount", count, 1);
    drain();
    // randomized traffic
    for (int blk = 0; blk < 12; blk++) begin
      int rdp = $urandom_range(10, 70);
      thresh = CW'($urandom_range(0, 8));
      for (int c = 0; c < 250; c++) begin
        @(negedge clk);
        if (rx_rdy && rx_clr_rdy) rx_rdy = 0;
        else if (!rx_rdy && $urandom_range(1)) begin rx_rdy = 1; rx_data = 8'($urandom); end
        rd_en = $urandom_range(99) < rdp;
        ovr_clr = $urandom_range(99) < 4;
      end
    end
    @(negedge clk);
    rx_rdy = 0; rd_en = 0; ovr_clr = 0; thresh = 0;
    @(negedge clk);
    drain();
    ovr_clr = 1; @(negedge clk); ovr_clr = 0;
    // idle timeout
    send(8'h77);
    begin
      int k = 0;
      while (!rx_timeout && k < 700) begin @(negedge clk); k++; end
`ifdef RX_TIMEOUT_EN
      chk("to_clks", k, 640);
      @(negedge clk);
      chk("to_irq", irq, 1);
      pop1();
      chk("to_cleared", rx_timeout, 0);
`else
      chk("to_never", k, 700);
      chk("to_low", rx_timeout, 0);
`endif
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
